// File: rtl/life_pkg.sv
// Shared types, rule constants and helpers for the Game-of-Life grid engine.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FINISH  = 2'd2
  } state_e;

  localparam logic [8:0] CONWAY_BIRTH   = 9'b000001000;
  localparam logic [8:0] CONWAY_SURVIVE = 9'b000001100;

  // Neighbour count of one cell: number of set bits in its 8-neighbourhood.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/life_row_update.sv
// Combinational next-generation of one grid row from its old neighbours above/below.
module life_row_update
  import life_pkg::*;
#(
  parameter int unsigned GRID_W = 32,
  localparam int unsigned CNT_W = $clog2(GRID_W) + 1
) (
  input  logic [GRID_W-1:0] above_i,
  input  logic [GRID_W-1:0] cur_i,
  input  logic [GRID_W-1:0] below_i,
  input  logic              wrap_en_i,
  input  logic [8:0]        birth_mask_i,
  input  logic [8:0]        survive_mask_i,
  output logic [GRID_W-1:0] next_row_o,
  output logic [CNT_W-1:0]  row_pop_o
);

  // Rows padded with one column each side: LSB is column -1, MSB is column GRID_W.
  logic [GRID_W+1:0] above_x;
  logic [GRID_W+1:0] cur_x;
  logic [GRID_W+1:0] below_x;
  logic [7:0]        nb;
  logic [3:0]        n;

  assign above_x = {wrap_en_i & above_i[0], above_i, wrap_en_i & above_i[GRID_W-1]};
  assign cur_x   = {wrap_en_i & cur_i[0],   cur_i,   wrap_en_i & cur_i[GRID_W-1]};
  assign below_x = {wrap_en_i & below_i[0], below_i, wrap_en_i & below_i[GRID_W-1]};

  always_comb begin
    next_row_o = '0;
    row_pop_o  = '0;
    nb         = '0;
    n          = '0;
    for (int j = 0; j < int'(GRID_W); j++) begin
      nb = {above_x[j], above_x[j+1], above_x[j+2],
            cur_x[j],                 cur_x[j+2],
            below_x[j], below_x[j+1], below_x[j+2]};
      n  = popcount8(nb);
      next_row_o[j] = cur_x[j+1] ? survive_mask_i[n] : birth_mask_i[n];
      row_pop_o     = row_pop_o + CNT_W'(next_row_o[j]);
    end
  end

endmodule

// File: rtl/life_grid_engine.sv
// Register-held Game-of-Life grid, updated in place one row per clock, with
// load/read ports, step and auto-run control, and generation statistics.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int unsigned GRID_W = 32,
  parameter int unsigned GRID_H = 24,
  parameter int unsigned GEN_W  = 16,
  parameter int unsigned PER_W  = 26,
  localparam int unsigned ROW_W = $clog2(GRID_H),
  localparam int unsigned POP_W = ROW_W + $clog2(GRID_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_en,
  input  logic [ROW_W-1:0]  load_row,
  input  logic [GRID_W-1:0] load_data,
  input  logic              step,
  input  logic              run_en,
  input  logic [PER_W-1:0]  period,
  input  logic              wrap_en,
  input  logic [8:0]        birth_mask,
  input  logic [8:0]        survive_mask,
  input  logic [ROW_W-1:0]  rd_row,
  output logic [GRID_W-1:0] rd_data,
  output logic              busy,
  output logic              gen_done,
  output logic [GEN_W-1:0]  generation,
  output logic [POP_W-1:0]  population,
  output logic              extinct,
  output logic              stable
);

  localparam int unsigned      CNT_W    = $clog2(GRID_W) + 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID_H - 1);

  state_e              state_q;
  logic [GRID_W-1:0]   grid_q [GRID_H];
  logic [ROW_W-1:0]    r_q;
  logic [GRID_W-1:0]   prev_buf_q;
  logic [GRID_W-1:0]   first_buf_q;
  logic                wrap_q;
  logic [8:0]          birth_q;
  logic [8:0]          survive_q;
  logic [POP_W-1:0]    pop_acc_q;
  logic                chg_acc_q;
  logic [PER_W-1:0]    per_cnt_q;
  logic [GRID_W-1:0]   rd_data_q;
  logic                busy_q;
  logic                gen_done_q;
  logic [GEN_W-1:0]    generation_q;
  logic [POP_W-1:0]    population_q;
  logic                extinct_q;
  logic                stable_q;

  logic [PER_W-1:0]    per_last_c;
  logic                tick_c;
  logic                step_req_c;
  logic                load_ok_c;
  logic                rd_ok_c;
  logic                last_row_c;
  logic [ROW_W-1:0]    r_below_c;
  logic [GRID_W-1:0]   above_c;
  logic [GRID_W-1:0]   cur_c;
  logic [GRID_W-1:0]   below_c;
  logic [GRID_W-1:0]   next_c;
  logic [CNT_W-1:0]    row_pop_c;
  logic [POP_W-1:0]    pop_total_c;
  logic                chg_total_c;

  // A period of 0 behaves like 1: tick every cycle.
  assign per_last_c = (period == '0) ? '0 : period - PER_W'(1);
  assign tick_c     = run_en && (per_cnt_q >= per_last_c);
  assign step_req_c = step | tick_c;
  assign load_ok_c  = load_en && (32'(load_row) < GRID_H);
  assign rd_ok_c    = 32'(rd_row) < GRID_H;
  assign last_row_c = (r_q == LAST_ROW);
  assign r_below_c  = last_row_c ? '0 : r_q + ROW_W'(1);
  assign cur_c      = grid_q[r_q];

  // Row 0 sees the still-old last row; the last row sees the saved old row 0.
  always_comb begin
    above_c = prev_buf_q;
    below_c = grid_q[r_below_c];
    if (r_q == '0) begin
      above_c = wrap_q ? grid_q[GRID_H-1] : '0;
    end
    if (last_row_c) begin
      below_c = wrap_q ? first_buf_q : '0;
    end
  end

  life_row_update #(
    .GRID_W(GRID_W)
  ) u_row_update (
    .above_i        (above_c),
    .cur_i          (cur_c),
    .below_i        (below_c),
    .wrap_en_i      (wrap_q),
    .birth_mask_i   (birth_q),
    .survive_mask_i (survive_q),
    .next_row_o     (next_c),
    .row_pop_o      (row_pop_c)
  );

  assign pop_total_c = pop_acc_q + POP_W'(row_pop_c);
  assign chg_total_c = chg_acc_q | (next_c != cur_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      for (int i = 0; i < int'(GRID_H); i++) grid_q[i] <= '0;
      r_q          <= '0;
      prev_buf_q   <= '0;
      first_buf_q  <= '0;
      wrap_q       <= 1'b0;
      birth_q      <= '0;
      survive_q    <= '0;
      pop_acc_q    <= '0;
      chg_acc_q    <= 1'b0;
      per_cnt_q    <= '0;
      rd_data_q    <= '0;
      busy_q       <= 1'b0;
      gen_done_q   <= 1'b0;
      generation_q <= '0;
      population_q <= '0;
      extinct_q    <= 1'b0;
      stable_q     <= 1'b0;
    end else if (clear) begin
      state_q      <= IDLE;
      for (int i = 0; i < int'(GRID_H); i++) grid_q[i] <= '0;
      r_q          <= '0;
      pop_acc_q    <= '0;
      chg_acc_q    <= 1'b0;
      per_cnt_q    <= '0;
      rd_data_q    <= '0;
      busy_q       <= 1'b0;
      gen_done_q   <= 1'b0;
      generation_q <= '0;
      population_q <= '0;
      extinct_q    <= 1'b0;
      stable_q     <= 1'b0;
    end else begin
      gen_done_q <= 1'b0;
      rd_data_q  <= rd_ok_c ? grid_q[rd_row] : '0;
      if (!run_en || tick_c) begin
        per_cnt_q <= '0;
      end else begin
        per_cnt_q <= per_cnt_q + PER_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (load_ok_c) begin
            grid_q[load_row] <= load_data;
          end
          if (step_req_c) begin
            state_q   <= COMPUTE;
            busy_q    <= 1'b1;
            r_q       <= '0;
            wrap_q    <= wrap_en;
            birth_q   <= birth_mask;
            survive_q <= survive_mask;
            pop_acc_q <= '0;
            chg_acc_q <= 1'b0;
          end
        end
        COMPUTE: begin
          grid_q[r_q] <= next_c;
          prev_buf_q  <= cur_c;
          if (r_q == '0) begin
            first_buf_q <= cur_c;
          end
          pop_acc_q <= pop_total_c;
          chg_acc_q <= chg_total_c;
          if (last_row_c) begin
            state_q      <= FINISH;
            gen_done_q   <= 1'b1;
            population_q <= pop_total_c;
            extinct_q    <= (pop_total_c == '0);
            stable_q     <= !chg_total_c;
            generation_q <= generation_q + GEN_W'(1);
          end else begin
            r_q <= r_q + ROW_W'(1);
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign gen_done   = gen_done_q;
  assign generation = generation_q;
  assign population = population_q;
  assign extinct    = extinct_q;
  assign stable     = stable_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: rule/edge vector table plus timing and collision sequences.
module tb_life_grid_engine;
  import life_pkg::*;

  localparam int unsigned GW    = 32;
  localparam int unsigned GH    = 24;
  localparam int unsigned GEN_W = 16;
  localparam int unsigned PER_W = 26;
  localparam int unsigned ROW_W = $clog2(GH);
  localparam int unsigned POP_W = ROW_W + $clog2(GW) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              load_en;
  logic [ROW_W-1:0]  load_row;
  logic [GW-1:0]     load_data;
  logic              step;
  logic              run_en;
  logic [PER_W-1:0]  period;
  logic              wrap_en;
  logic [8:0]        birth_mask;
  logic [8:0]        survive_mask;
  logic [ROW_W-1:0]  rd_row;
  logic [GW-1:0]     rd_data;
  logic              busy;
  logic              gen_done;
  logic [GEN_W-1:0]  generation;
  logic [POP_W-1:0]  population;
  logic              extinct;
  logic              stable;

  life_grid_engine #(
    .GRID_W(GW), .GRID_H(GH), .GEN_W(GEN_W), .PER_W(PER_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .load_en(load_en), .load_row(load_row),
    .load_data(load_data), .step(step), .run_en(run_en), .period(period),
    .wrap_en(wrap_en), .birth_mask(birth_mask), .survive_mask(survive_mask),
    .rd_row(rd_row), .rd_data(rd_data), .busy(busy), .gen_done(gen_done),
    .generation(generation), .population(population), .extinct(extinct), .stable(stable)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0][4:0]  idx;
    logic [3:0][31:0] in_r;
    logic [3:0][31:0] out_r;
    logic             wrap;
    logic [8:0]       birth;
    logic [8:0]       survive;
    int               pop;
    logic             stable;
    logic             extinct;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic [19:0] idx, input logic [127:0] in_r,
                              input logic [127:0] out_r, input logic wrap,
                              input logic [8:0] b, input logic [8:0] s,
                              input int pop, input logic st, input logic ex);
    vec_t v;
    v.idx = idx; v.in_r = in_r; v.out_r = out_r; v.wrap = wrap;
    v.birth = b; v.survive = s; v.pop = pop; v.stable = st; v.extinct = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic read_row(input int idx, output logic [GW-1:0] d);
    rd_row = ROW_W'(idx);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic load_row_t(input int idx, input logic [GW-1:0] d);
    load_en = 1'b1; load_row = ROW_W'(idx); load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  // n = negedges until gen_done is seen, -1 if the bound expires.
  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (gen_done) begin
        n = i;
        break;
      end
    end
  endtask

  // Pulse step for one cycle, return cycles to gen_done, then return to idle.
  task automatic step_gen(output int lat);
    int n;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    lat = 1;
    if (!gen_done) begin
      wait_done(40, n);
      lat = (n < 0) ? -1 : n + 1;
    end
    chk("gen_done_seen", 64'(lat > 0), 64'(1));
    @(negedge clk);
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (gen_done) cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [GW-1:0] d;
    int lat, n, t0, t1, cnt;

    vecs[0] = mk({5'd13, 5'd12, 5'd11, 5'd10}, {32'h0, 32'h20, 32'h20, 32'h20},
                 {32'h0, 32'h0, 32'h70, 32'h0}, 1'b0, CONWAY_BIRTH, CONWAY_SURVIVE, 3, 1'b0, 1'b0);
    vecs[1] = mk({5'd23, 5'd2, 5'd1, 5'd0}, {32'h0, 32'h0, 32'h3, 32'h3},
                 {32'h0, 32'h0, 32'h3, 32'h3}, 1'b1, CONWAY_BIRTH, CONWAY_SURVIVE, 4, 1'b1, 1'b0);
    vecs[2] = mk({5'd22, 5'd1, 5'd0, 5'd23}, {32'h0, 32'h0, 32'h80000001, 32'h80000001},
                 {32'h0, 32'h0, 32'h80000001, 32'h80000001}, 1'b1, CONWAY_BIRTH, CONWAY_SURVIVE, 4, 1'b1, 1'b0);
    vecs[3] = mk({5'd22, 5'd1, 5'd0, 5'd23}, {32'h0, 32'h0, 32'h80000001, 32'h80000001},
                 {32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, CONWAY_BIRTH, CONWAY_SURVIVE, 0, 1'b0, 1'b1);
    vecs[4] = mk({5'd7, 5'd6, 5'd5, 5'd4}, {32'h0, 32'h0, 32'h80, 32'h0},
                 {32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, CONWAY_BIRTH, CONWAY_SURVIVE, 0, 1'b0, 1'b1);
    vecs[5] = mk({5'd6, 5'd5, 5'd4, 5'd3}, {32'h0, 32'h0, 32'h80000001, 32'hF0F01234},
                 {32'h0, 32'h0, 32'h80000001, 32'hF0F01234}, 1'b1, 9'h000, 9'h1FF, 15, 1'b1, 1'b0);
    vecs[6] = mk({5'd2, 5'd1, 5'd0, 5'd23}, {32'h0, 32'h0, 32'h70, 32'h0},
                 {32'h0, 32'h20, 32'h20, 32'h20}, 1'b1, CONWAY_BIRTH, CONWAY_SURVIVE, 3, 1'b0, 1'b0);
    vecs[7] = mk({5'd23, 5'd2, 5'd1, 5'd0}, {32'h0, 32'h0, 32'h0, 32'h70},
                 {32'h0, 32'h0, 32'h20, 32'h20}, 1'b0, CONWAY_BIRTH, CONWAY_SURVIVE, 2, 1'b0, 1'b0);
    vecs[8] = mk({5'd12, 5'd11, 5'd10, 5'd9}, {32'h0, 32'h0, 32'h80000003, 32'h0},
                 {32'h0, 32'h1, 32'h1, 32'h1}, 1'b1, CONWAY_BIRTH, CONWAY_SURVIVE, 3, 1'b0, 1'b0);
    vecs[9] = mk({5'd7, 5'd6, 5'd5, 5'd4}, {32'h0, 32'h0, 32'h400, 32'h0},
                 {32'h0, 32'hE00, 32'hA00, 32'hE00}, 1'b0, 9'h002, 9'h000, 8, 1'b0, 1'b0);

    rst = 1'b1; clear = 1'b0; load_en = 1'b0; load_row = '0; load_data = '0;
    step = 1'b0; run_en = 1'b0; period = '0; wrap_en = 1'b0;
    birth_mask = CONWAY_BIRTH; survive_mask = CONWAY_SURVIVE; rd_row = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset busy", 64'(busy), 64'(0));
    chk("reset gen_done", 64'(gen_done), 64'(0));
    chk("reset generation", 64'(generation), 64'(0));
    chk("reset population", 64'(population), 64'(0));
    chk("reset extinct", 64'(extinct), 64'(0));
    chk("reset stable", 64'(stable), 64'(0));
    chk("reset rd_data", 64'(rd_data), 64'(0));

    // Rule and edge vectors
    for (int i = 0; i < 10; i++) begin
      do_clear();
      for (int k = 0; k < 4; k++) load_row_t(int'(vecs[i].idx[k]), vecs[i].in_r[k]);
      wrap_en = vecs[i].wrap; birth_mask = vecs[i].birth; survive_mask = vecs[i].survive;
      step_gen(lat);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(25));
      chk($sformatf("v%0d generation", i), 64'(generation), 64'(1));
      chk($sformatf("v%0d population", i), 64'(population), 64'(vecs[i].pop));
      chk($sformatf("v%0d stable", i), 64'(stable), 64'(vecs[i].stable));
      chk($sformatf("v%0d extinct", i), 64'(extinct), 64'(vecs[i].extinct));
      for (int k = 0; k < 4; k++) begin
        read_row(int'(vecs[i].idx[k]), d);
        chk($sformatf("v%0d row%0d", i, vecs[i].idx[k]), 64'(d), 64'(vecs[i].out_r[k]));
      end
    end

    // Exact latency, with the last blinker row loaded in the same cycle as step
    do_clear();
    wrap_en = 1'b0; birth_mask = CONWAY_BIRTH; survive_mask = CONWAY_SURVIVE;
    load_row_t(10, 32'h20);
    load_row_t(11, 32'h20);
    load_en = 1'b1; load_row = ROW_W'(12); load_data = 32'h20; step = 1'b1;
    @(negedge clk);
    load_en = 1'b0; step = 1'b0;
    chk("lat busy_t+1", 64'(busy), 64'(1));
    wait_done(40, n);
    chk("lat gen_done_t+25", 64'(n + 1), 64'(25));
    @(negedge clk);
    chk("lat busy_t+26", 64'(busy), 64'(0));
    chk("lat gen_done_low", 64'(gen_done), 64'(0));
    read_row(10, d); chk("lat row10", 64'(d), 64'(0));
    read_row(11, d); chk("lat row11", 64'(d), 64'(32'h70));
    read_row(12, d); chk("lat row12", 64'(d), 64'(0));
    step_gen(lat);
    for (int r = 10; r <= 12; r++) begin
      read_row(r, d);
      chk($sformatf("blinker2 row%0d", r), 64'(d), 64'(32'h20));
    end
    chk("blinker2 generation", 64'(generation), 64'(2));

    // Out-of-range load and read
    do_clear();
    load_row_t(1, 32'h1234);
    load_row_t(25, 32'hDEADBEEF);
    read_row(1, d);  chk("oob row1", 64'(d), 64'(32'h1234));
    read_row(23, d); chk("oob row23", 64'(d), 64'(0));
    read_row(25, d); chk("oob rd25", 64'(d), 64'(0));

    // Glider on the torus: 96 generations move it +24 rows, +24 columns
    do_clear();
    wrap_en = 1'b1; birth_mask = CONWAY_BIRTH; survive_mask = CONWAY_SURVIVE;
    load_row_t(20, 32'h1 << 29);
    load_row_t(21, 32'h1 << 30);
    load_row_t(22, 32'h7 << 28);
    for (int g = 1; g <= 96; g++) begin
      step_gen(lat);
      chk($sformatf("glider pop g%0d", g), 64'(population), 64'(5));
    end
    chk("glider generation", 64'(generation), 64'(96));
    read_row(19, d); chk("glider row19", 64'(d), 64'(0));
    read_row(20, d); chk("glider row20", 64'(d), 64'(32'h1 << 21));
    read_row(21, d); chk("glider row21", 64'(d), 64'(32'h1 << 22));
    read_row(22, d); chk("glider row22", 64'(d), 64'(32'h7 << 20));
    read_row(23, d); chk("glider row23", 64'(d), 64'(0));

    // Auto-run: period 30, then period 10 with ticks dropped while busy
    do_clear();
    wrap_en = 1'b0;
    load_row_t(11, 32'h70);
    period = PER_W'(30); run_en = 1'b1;
    wait_done(100, n); chk("auto30 first", 64'(n > 0), 64'(1));
    for (int k = 0; k < 2; k++) begin
      t0 = cyc; wait_done(60, n); t1 = cyc;
      chk($sformatf("auto30 interval%0d", k), 64'(t1 - t0), 64'(30));
    end
    run_en = 1'b0;
    repeat (30) @(negedge clk);
    period = PER_W'(10); run_en = 1'b1;
    wait_done(100, n); chk("auto10 first", 64'(n > 0), 64'(1));
    for (int k = 0; k < 2; k++) begin
      t0 = cyc; wait_done(60, n); t1 = cyc;
      chk($sformatf("auto10 interval%0d", k), 64'(t1 - t0), 64'(30));
    end
    run_en = 1'b0;
    repeat (30) @(negedge clk);

    // Load and step while busy are ignored
    do_clear();
    for (int r = 10; r <= 12; r++) load_row_t(r, 32'h20);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    load_en = 1'b1; load_row = '0; load_data = 32'hFFFF; step = 1'b1;
    @(negedge clk);
    load_en = 1'b0; step = 1'b0;
    wait_done(40, n); chk("busy gen_done", 64'(n > 0), 64'(1));
    count_pulses(40, cnt);
    chk("busy extra gen_done", 64'(cnt), 64'(0));
    chk("busy generation", 64'(generation), 64'(1));
    read_row(0, d);  chk("busy row0", 64'(d), 64'(0));
    read_row(11, d); chk("busy row11", 64'(d), 64'(32'h70));

    // Clear mid-COMPUTE aborts the generation
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (5) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    count_pulses(40, cnt);
    chk("clear gen_done", 64'(cnt), 64'(0));
    chk("clear generation", 64'(generation), 64'(0));
    chk("clear population", 64'(population), 64'(0));
    chk("clear busy", 64'(busy), 64'(0));
    read_row(11, d); chk("clear row11", 64'(d), 64'(0));

    // rst mid-COMPUTE returns every output to its reset value
    for (int r = 10; r <= 12; r++) load_row_t(r, 32'h20);
    step_gen(lat);
    chk("pre-rst population", 64'(population), 64'(3));
    load_row_t(5, 32'hA5);
    rd_row = ROW_W'(5);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst gen_done", 64'(gen_done), 64'(0));
    chk("rst generation", 64'(generation), 64'(0));
    chk("rst population", 64'(population), 64'(0));
    chk("rst extinct", 64'(extinct), 64'(0));
    chk("rst stable", 64'(stable), 64'(0));
    chk("rst rd_data", 64'(rd_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    read_row(11, d); chk("rst row11", 64'(d), 64'(0));
    read_row(5, d);  chk("rst row5", 64'(d), 64'(0));
    chk("rst busy after", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_grid_engine.md
Name: life_grid_engine

Overview:
- Parametrised Game-of-Life engine: holds a GRID_H x GRID_W cell grid in registers and computes one generation row-serially, one row per clk, updating in place.
- Adds what the per-cell array lacks:
  - rule masks for any B/S rule
  - toroidal or dead-boundary edges
  - row-wise load and read ports
  - step and auto-run control
  - generation counter, population count, and extinct/stable flags
- Sits between the pattern loader/keys and the VGA renderer, which reads rows through the rd port.

Parameters:
- GRID_W, 32, cells per row (>=3)
- GRID_H, 24, rows (>=3)
- GEN_W, 16, generation counter width
- PER_W, 26, auto-run period counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous clear of grid and counters
- load_en  in  1  write load_data into row load_row
- load_row  in  ROW_W=$clog2(GRID_H)  row index for load
- load_data  in  GRID_W  row contents; bit j = column j
- step  in  1  single-cycle request for one generation
- run_en  in  1  auto-step every period cycles
- period  in  PER_W  auto-run period in clk cycles
- wrap_en  in  1  1 = toroidal, 0 = outside cells dead
- birth_mask  in  9  bit n set: dead cell with n neighbours is born
- survive_mask  in  9  bit n set: live cell with n neighbours survives
- rd_row  in  ROW_W  read row index
- rd_data  out  GRID_W  registered grid[rd_row]
- busy  out  1  generation in progress
- gen_done  out  1  one-cycle pulse when a generation completes
- generation  out  GEN_W  completed generations, wraps modulo 2^GEN_W
- population  out  ROW_W+$clog2(GRID_W)+1  live cells after last generation
- extinct  out  1  population==0 after last generation
- stable  out  1  last generation changed no cell

Behaviour:
- Reset: grid all 0; rd_data 0; busy 0; gen_done 0; generation 0; population 0; extinct 0; stable 0; FSM IDLE; period counter 0.
- FSM states: IDLE, COMPUTE, FINISH.
  - IDLE -> COMPUTE on an accepted step request; row index r=0.
  - COMPUTE: one row per cycle; r==GRID_H-1 -> FINISH.
  - FINISH (1 cycle) -> IDLE; gen_done=1 this cycle.
- Step request = step OR auto tick. Accepted only in IDLE; otherwise dropped (no queuing).
- Latency: step at cycle t -> busy from t+1; gen_done at t+GRID_H+1; busy low at t+GRID_H+2.
- Auto tick:
  - Period counter runs only while run_en=1 and counts 0..max(period,1)-1.
  - Tick at wrap; counter resets to 0 when run_en=0.
- In-place update per row r (all reads from pre-generation values):
  - above = prev_buf (old row r-1), or the unmodified array row GRID_H-1 for r=0.
  - cur = array[r].
  - below = array[r+1], or first_buf (old row 0) for r=GRID_H-1.
  - prev_buf <= old array[r] each cycle; first_buf <= old row 0 at r=0.
  - wrap_en=0: rows -1/GRID_H and columns -1/GRID_W read as 0. wrap_en=1: indices modulo size.
- Cell rule: n = 4-bit sum of 8 neighbours; next = cur ? survive_mask[n] : birth_mask[n].
- Statistics accumulate over COMPUTE: population sum of next-row popcounts; change flag = OR of (next != old).
- At FINISH:
  - population, extinct, stable updated.
  - generation += 1.
- wrap_en, birth_mask, survive_mask are sampled at step acceptance and held for the whole generation.
- Load:
  - Honoured only in IDLE; ignored while busy.
  - load_row >= GRID_H is ignored.
  - Load and accepted step in the same cycle: load is written, and the generation uses the loaded row.
- clear:
  - Highest priority after rst, in any state: grid 0, counters and flags 0, FSM IDLE.
  - A clear during COMPUTE aborts the generation; no gen_done.
- rd port:
  - rd_data <= grid[rd_row], 1-cycle latency.
  - rd_row >= GRID_H returns 0.
  - During COMPUTE, rows < r already hold the new generation; consumers sample when busy=0.
- rst mid-COMPUTE: immediate return to reset state.

Decomposition:
- life_pkg:
  - state enum {IDLE, COMPUTE, FINISH}
  - CONWAY_BIRTH=9'b000001000, CONWAY_SURVIVE=9'b000001100
  - function popcount8
- Sub-module life_row_update, combinational, parameter GRID_W:
  - inputs above/cur/below rows, wrap_en, masks
  - outputs next row and its popcount

Test Plan:
- Blinker: load rows 10-12 with a vertical blinker at column 5, Conway masks, wrap_en=0, step -> gen_done at step+25; row 11 = bits 4,5,6; population=3; generation=1; a second step restores the vertical blinker.
- Block: 2x2 block at rows 0-1, columns 0-1 with wrap_en=1 -> after one step stable=1, population=4. The same block split across the wrap corner (rows 23/0, columns 31/0) also stays stable=1.
- Glider wrap: glider near the bottom-right, wrap_en=1, 96 steps (4*24) -> glider restored at its start offset +(24 rows, 24 columns) mod grid; population=5 after every generation.
- Extinction and rules: single live cell -> population=0, extinct=1. With birth_mask=0 and survive_mask=9'h1FF -> grid unchanged and stable=1.
- Auto-run: run_en=1, period=30 -> gen_done every 30 cycles; period=10 (< GRID_H+2) -> ticks landing while busy are dropped, so gen_done comes every 30 cycles.
- Collisions:
  - load_en while busy -> row unchanged.
  - step while busy -> no extra generation.
  - clear mid-COMPUTE -> no gen_done, grid 0, generation 0.
  - rst mid-COMPUTE -> all outputs at reset values.
